fetch_pc_gen: RTL and testbench

- Parametrised fetch program-counter generator, the next generation of the core's PC stage.
- Drives the I-cache request address with a valid/ready handshake.
- Arbitrates trap, branch and sequential next-PC, and holds on pipeline stalls.
- Latches redirects that arrive while a request is stalled, and halts on an illegal all-zero instruction until a redirect arrives.

---
 rtl/fetch_pc_gen.sv | 131 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch program-counter generator with I-cache valid/ready request,
// trap/branch redirect arbitration, stalled-redirect latching and halt on all-zero instruction.
`default_nettype none

module fetch_pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_in,
  input  logic             inst_valid,
  input  logic             req_ready,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vec,
  output logic [XLEN-1:0]  pc_out,
  output logic             req_valid,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state;
  logic            pend_valid;
  logic            pend_trap;
  logic [XLEN-1:0] pend_pc;

  logic            fire;
  logic            new_redir;
  logic            has_redir;
  logic            take;
  logic            halt_req;
  logic            sel_is_trap;
  logic [XLEN-1:0] sel;

  assign req_valid = (state == S_RUN) && !stall;
  assign halted    = (state == S_HALT);
  assign fire      = req_valid && req_ready;
  assign new_redir = trap_valid || br_valid;
  assign has_redir = new_redir || pend_valid;
  assign take      = has_redir && (fire || !req_valid);
  assign halt_req  = inst_valid && (inst_in == 32'd0);

  // A latched trap outranks a fresh branch, so a branch can never displace it.
  always_comb begin
    sel         = pend_pc;
    sel_is_trap = 1'b0;
    if (trap_valid) begin
      sel         = trap_vec;
      sel_is_trap = 1'b1;
    end else if (pend_valid && pend_trap) begin
      sel         = pend_pc;
      sel_is_trap = 1'b1;
    end else if (br_valid) begin
      sel         = br_target;
      sel_is_trap = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc_out     <= RESET_VEC;
      redirect   <= 1'b0;
      fetch_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
      pend_pc    <= '0;
    end else begin
      redirect <= 1'b0;
      if (fire && (fetch_cnt != {CNT_W{1'b1}})) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end

      case (state)
        S_BOOT: begin
          state <= S_RUN;
          if (new_redir) begin
            pend_valid <= 1'b1;
            pend_trap  <= sel_is_trap;
            pend_pc    <= sel;
          end
        end

        S_RUN: begin
          if (take) begin
            pc_out     <= sel;
            redirect   <= 1'b1;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
          end else if (has_redir) begin
            // Request outstanding and not accepted: the address must stay put.
            pend_valid <= 1'b1;
            pend_trap  <= sel_is_trap;
            pend_pc    <= sel;
          end else if (halt_req) begin
            state <= S_HALT;
          end else if (fire) begin
            pc_out <= pc_out + XLEN'(INST_BYTES);
          end
        end

        S_HALT: begin
          if (new_redir) begin
            pc_out     <= sel;
            redirect   <= 1'b1;
            state      <= S_RUN;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a 32-bit instance for the main flow and an 8-bit instance for wrap/reset.
`default_nettype none

module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // 32-bit instance
  logic        rst_a, inst_valid_a, req_ready_a, stall_a, br_valid_a, trap_valid_a;
  logic [31:0] inst_in_a, br_target_a, trap_vec_a, pc_a;
  logic        req_valid_a, redirect_a, halted_a;
  logic [15:0] cnt_a;

  // 8-bit instance
  logic        rst_b, inst_valid_b, req_ready_b, stall_b, br_valid_b, trap_valid_b;
  logic [31:0] inst_in_b;
  logic [7:0]  br_target_b, trap_vec_b, pc_b;
  logic        req_valid_b, redirect_b, halted_b;
  logic [15:0] cnt_b;

  fetch_pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0100), .INST_BYTES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .inst_in(inst_in_a), .inst_valid(inst_valid_a),
    .req_ready(req_ready_a), .stall(stall_a), .br_valid(br_valid_a), .br_target(br_target_a),
    .trap_valid(trap_valid_a), .trap_vec(trap_vec_a), .pc_out(pc_a), .req_valid(req_valid_a),
    .redirect(redirect_a), .halted(halted_a), .fetch_cnt(cnt_a)
  );

  fetch_pc_gen #(.XLEN(8), .RESET_VEC(8'hFC), .INST_BYTES(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .inst_in(inst_in_b), .inst_valid(inst_valid_b),
    .req_ready(req_ready_b), .stall(stall_b), .br_valid(br_valid_b), .br_target(br_target_b),
    .trap_valid(trap_valid_b), .trap_vec(trap_vec_b), .pc_out(pc_b), .req_valid(req_valid_b),
    .redirect(redirect_b), .halted(halted_b), .fetch_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; inst_valid_a = 1'b0; req_ready_a = 1'b1; stall_a = 1'b0;
    br_valid_a = 1'b0; trap_valid_a = 1'b0; inst_in_a = 32'h13;
    br_target_a = '0; trap_vec_a = '0;
    rst_b = 1'b1; inst_valid_b = 1'b0; req_ready_b = 1'b1; stall_b = 1'b0;
    br_valid_b = 1'b0; trap_valid_b = 1'b0; inst_in_b = 32'h13;
    br_target_b = '0; trap_vec_b = '0;

    // Reset state
    step();
    chk("rst_pc", pc_a, 32'h100);
    chk("rst_req_valid", {31'd0, req_valid_a}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_a}, 32'd0);
    chk("rst_halted", {31'd0, halted_a}, 32'd0);
    rst_a = 1'b0;
    chk("boot_req_valid", {31'd0, req_valid_a}, 32'd0);

    // Sequential fetch
    step();
    chk("run_req_valid", {31'd0, req_valid_a}, 32'd1);
    chk("seq_pc0", pc_a, 32'h100);
    step();
    chk("seq_pc1", pc_a, 32'h104);
    step();
    chk("seq_pc2", pc_a, 32'h108);
    chk("seq_cnt2", {16'd0, cnt_a}, 32'd2);

    // Branch while request is not accepted: latched, applied on accept
    req_ready_a = 1'b0; br_valid_a = 1'b1; br_target_a = 32'h200;
    step();
    br_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_pc", pc_a, 32'h108);
      chk("hold_req_valid", {31'd0, req_valid_a}, 32'd1);
      chk("hold_redirect", {31'd0, redirect_a}, 32'd0);
      if (i < 2) step();
    end
    req_ready_a = 1'b1;
    step();
    chk("pend_pc", pc_a, 32'h200);
    chk("pend_redirect", {31'd0, redirect_a}, 32'd1);
    chk("pend_cnt", {16'd0, cnt_a}, 32'd3);
    step();
    chk("pend_next_pc", pc_a, 32'h204);
    chk("pend_redirect_once", {31'd0, redirect_a}, 32'd0);

    // Trap beats branch in the same cycle
    br_valid_a = 1'b1; br_target_a = 32'h300; trap_valid_a = 1'b1; trap_vec_a = 32'h80;
    step();
    br_valid_a = 1'b0; trap_valid_a = 1'b0;
    chk("trap_pc", pc_a, 32'h80);
    step();
    chk("trap_next_pc", pc_a, 32'h84);

    // Halt on all-zero instruction at 0x20
    br_valid_a = 1'b1; br_target_a = 32'h20;
    step();
    br_valid_a = 1'b0;
    chk("br20_pc", pc_a, 32'h20);
    inst_valid_a = 1'b1; inst_in_a = 32'h0;
    step();
    inst_valid_a = 1'b0; inst_in_a = 32'h13;
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", {31'd0, halted_a}, 32'd1);
      chk("halt_req_valid", {31'd0, req_valid_a}, 32'd0);
      chk("halt_pc", pc_a, 32'h20);
      step();
    end
    chk("halt_cnt", {16'd0, cnt_a}, 32'd8);
    br_valid_a = 1'b1; br_target_a = 32'h40;
    step();
    br_valid_a = 1'b0;
    chk("unhalt_pc", pc_a, 32'h40);
    chk("unhalt_flag", {31'd0, halted_a}, 32'd0);
    chk("unhalt_redirect", {31'd0, redirect_a}, 32'd1);

    // Redirect during stall, then stall holds at 0x10
    stall_a = 1'b1; br_valid_a = 1'b1; br_target_a = 32'h10;
    step();
    br_valid_a = 1'b0;
    chk("stall_br_pc", pc_a, 32'h10);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_valid", {31'd0, req_valid_a}, 32'd0);
      chk("stall_pc", pc_a, 32'h10);
      chk("stall_cnt", {16'd0, cnt_a}, 32'd8);
    end
    stall_a = 1'b0;
    #1;
    chk("resume_req_valid", {31'd0, req_valid_a}, 32'd1);
    chk("resume_pc", pc_a, 32'h10);
    step();
    chk("resume_next_pc", pc_a, 32'h14);
    chk("resume_cnt", {16'd0, cnt_a}, 32'd9);

    // 8-bit instance: wrap, then async reset with a pending redirect
    rst_b = 1'b0;
    step();
    chk("b_pc0", {24'd0, pc_b}, 32'hFC);
    step();
    chk("b_wrap", {24'd0, pc_b}, 32'h00);
    step();
    chk("b_pc2", {24'd0, pc_b}, 32'h04);
    req_ready_b = 1'b0; br_valid_b = 1'b1; br_target_b = 8'h55;
    step();
    br_valid_b = 1'b0;
    chk("b_hold_pc", {24'd0, pc_b}, 32'h04);
    chk("b_hold_redirect", {31'd0, redirect_b}, 32'd0);
    #3;
    rst_b = 1'b1;
    #1;
    chk("b_async_pc", {24'd0, pc_b}, 32'hFC);
    chk("b_async_req_valid", {31'd0, req_valid_b}, 32'd0);
    step();
    rst_b = 1'b0; req_ready_b = 1'b1;
    step();
    chk("b_post_pc", {24'd0, pc_b}, 32'hFC);
    chk("b_post_redirect", {31'd0, redirect_b}, 32'd0);
    step();
    chk("b_no_pend_pc", {24'd0, pc_b}, 32'h00);
    chk("b_no_pend_redirect", {31'd0, redirect_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
